// File: rtl/nova_tty.sv
// Nova console teletype: TTI keyboard input and TTO printer output over one 8N1 UART.
// Bus strobes decode per device; Busy/Done flags drive skip status and the interrupt request.
module nova_tty #(
  parameter logic [5:0]  DEV_TTI = 6'o10,
  parameter logic [5:0]  DEV_TTO = 6'o11,
  parameter logic [15:0] CLK_DIV = 16'd434
) (
  input  logic        pclk,
  input  logic        prst_n,
  input  logic        bs_stb,
  input  logic        bs_we,
  input  logic [0:7]  bs_adr,
  input  logic [0:15] bs_din,
  output logic [0:15] bs_dout,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        tty_intr
);

  localparam logic [15:0] BitM1  = CLK_DIV - 16'd1;
  localparam logic [15:0] HalfM1 = (CLK_DIV >> 1) - 16'd1;

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  // Bus decode
  logic [5:0] dev;
  logic [1:0] rsel;
  logic [1:0] ctl;
  logic [7:0] wr_byte;
  logic       hit_tti, hit_tto;
  logic       tti_start, tti_clear, tto_start, tto_clear, tto_wr_buf;
  logic       unused_din;

  assign dev        = bs_adr[0:5];
  assign rsel       = bs_adr[6:7];
  assign ctl        = bs_din[14:15];
  assign wr_byte    = bs_din[8:15];
  assign unused_din = ^bs_din[0:7];

  assign hit_tti    = bs_stb & (dev == DEV_TTI);
  assign hit_tto    = bs_stb & (dev == DEV_TTO);
  assign tti_start  = hit_tti & bs_we & (rsel == 2'b00) & (ctl == 2'b01);
  assign tti_clear  = hit_tti & bs_we & (rsel == 2'b00) & (ctl == 2'b10);
  assign tto_start  = hit_tto & bs_we & (rsel == 2'b00) & (ctl == 2'b01);
  assign tto_clear  = hit_tto & bs_we & (rsel == 2'b00) & (ctl == 2'b10);
  assign tto_wr_buf = hit_tto & bs_we & (rsel == 2'b01);

  // Flags and buffers
  logic tti_busy_q, tti_busy_d, tti_done_q, tti_done_d;
  logic tto_busy_q, tto_busy_d, tto_done_q, tto_done_d;
  logic [7:0] rx_buf_q, rx_buf_d;
  logic [7:0] tx_buf_q, tx_buf_d;
  logic [15:0] rd_data, bs_dout_q;

  // Transmitter state
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shf_q, tx_shf_d;
  logic        tx_out_q, tx_out_d;
  logic        tx_done_evt;

  // Receiver state
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shf_q, rx_shf_d;
  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  logic        rx_fall;
  logic        rx_done_evt;

  assign rx_fall = rx_prev_q & ~rx_sync_q;

  always_comb begin
    rd_data = 16'h0000;
    if (bs_stb && !bs_we) begin
      if (hit_tti) begin
        case (rsel)
          2'b00:   rd_data = {tti_busy_q, tti_done_q, 14'b0};
          2'b01:   rd_data = {8'h00, rx_buf_q};
          default: rd_data = 16'h0000;
        endcase
      end else if (hit_tto) begin
        case (rsel)
          2'b00:   rd_data = {tto_busy_q, tto_done_q, 14'b0};
          2'b01:   rd_data = {8'h00, tx_buf_q};
          default: rd_data = 16'h0000;
        endcase
      end
    end
  end

  // TX: uart_tx follows the state one edge late, so the start bit appears after the Start edge
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_shf_d    = tx_shf_q;
    tx_out_d    = 1'b1;
    tx_done_evt = 1'b0;
    case (tx_state_q)
      TxIdle: tx_out_d = 1'b1;
      TxStart: begin
        tx_out_d = 1'b0;
        if (tx_cnt_q == BitM1) begin
          tx_state_d = TxData;
          tx_cnt_d   = 16'd0;
          tx_bit_d   = 3'd0;
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      TxData: begin
        tx_out_d = tx_shf_q[0];
        if (tx_cnt_q == BitM1) begin
          tx_cnt_d = 16'd0;
          tx_shf_d = {1'b0, tx_shf_q[7:1]};
          if (tx_bit_q == 3'd7) tx_state_d = TxStop;
          else                  tx_bit_d   = tx_bit_q + 3'd1;
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      TxStop: begin
        tx_out_d = 1'b1;
        if (tx_cnt_q == BitM1) begin
          tx_state_d  = TxIdle;
          tx_cnt_d    = 16'd0;
          tx_done_evt = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
    // A Start landing on the completion edge begins the next frame so busy never sticks
    if (tto_clear) begin
      tx_state_d = TxIdle;
      tx_cnt_d   = 16'd0;
    end else if (tto_start && (tx_state_q == TxIdle || tx_done_evt)) begin
      tx_state_d = TxStart;
      tx_cnt_d   = 16'd0;
      tx_bit_d   = 3'd0;
      tx_shf_d   = tx_buf_q;
    end
  end

  // RX: start bit is re-checked at mid-bit, then every bit is sampled one period later
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shf_d    = rx_shf_q;
    rx_buf_d    = rx_buf_q;
    rx_done_evt = 1'b0;
    case (rx_state_q)
      RxIdle: begin
        if (rx_fall) begin
          rx_state_d = RxStart;
          rx_cnt_d   = 16'd0;
        end
      end
      RxStart: begin
        if (rx_cnt_q == HalfM1) begin
          rx_cnt_d   = 16'd0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RxData: begin
        if (rx_cnt_q == BitM1) begin
          rx_cnt_d = 16'd0;
          rx_shf_d = {rx_sync_q, rx_shf_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RxStop: begin
        if (rx_cnt_q == BitM1) begin
          rx_cnt_d   = 16'd0;
          rx_state_d = RxIdle;
          if (rx_sync_q) begin
            rx_buf_d    = rx_shf_q;
            rx_done_evt = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // Control writes take priority over a frame completing on the same edge
  always_comb begin
    tti_busy_d = tti_busy_q;
    tti_done_d = tti_done_q;
    tto_busy_d = tto_busy_q;
    tto_done_d = tto_done_q;
    tx_buf_d   = tto_wr_buf ? wr_byte : tx_buf_q;
    if (rx_done_evt) begin
      tti_busy_d = 1'b0;
      tti_done_d = 1'b1;
    end
    if (tti_start) begin
      tti_busy_d = 1'b1;
      tti_done_d = 1'b0;
    end else if (tti_clear) begin
      tti_busy_d = 1'b0;
      tti_done_d = 1'b0;
    end
    if (tx_done_evt) begin
      tto_busy_d = 1'b0;
      tto_done_d = 1'b1;
    end
    if (tto_start) begin
      tto_busy_d = 1'b1;
      tto_done_d = 1'b0;
    end else if (tto_clear) begin
      tto_busy_d = 1'b0;
      tto_done_d = 1'b0;
    end
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      tti_busy_q <= 1'b0;
      tti_done_q <= 1'b0;
      tto_busy_q <= 1'b0;
      tto_done_q <= 1'b0;
      rx_buf_q   <= 8'h00;
      tx_buf_q   <= 8'h00;
      bs_dout_q  <= 16'h0000;
    end else begin
      tti_busy_q <= tti_busy_d;
      tti_done_q <= tti_done_d;
      tto_busy_q <= tto_busy_d;
      tto_done_q <= tto_done_d;
      rx_buf_q   <= rx_buf_d;
      tx_buf_q   <= tx_buf_d;
      if (bs_stb) bs_dout_q <= rd_data;
    end
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= 16'd0;
      tx_bit_q   <= 3'd0;
      tx_shf_q   <= 8'h00;
      tx_out_q   <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shf_q   <= tx_shf_d;
      tx_out_q   <= tx_out_d;
    end
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      rx_state_q <= RxIdle;
      rx_cnt_q   <= 16'd0;
      rx_bit_q   <= 3'd0;
      rx_shf_q   <= 8'h00;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shf_q   <= rx_shf_d;
      rx_meta_q  <= uart_rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
    end
  end

  assign bs_dout  = bs_dout_q;
  assign uart_tx  = tx_out_q;
  assign tty_intr = tti_done_q | tto_done_q;

endmodule

// File: tb/tb_nova_tty.sv
// Directed bench for nova_tty with CLK_DIV=8: bus status/data, TX frame timing, RX frames,
// false start, abort, Start-while-busy and asynchronous reset.
module tb_nova_tty;

  logic        pclk;
  logic        prst_n;
  logic        bs_stb;
  logic        bs_we;
  logic [0:7]  bs_adr;
  logic [0:15] bs_din;
  logic [0:15] bs_dout;
  logic        uart_rx;
  logic        uart_tx;
  logic        tty_intr;

  int total;
  int bad;
  int cyc;

  localparam logic [7:0] TtiCtl = 8'h20;
  localparam logic [7:0] TtiDat = 8'h21;
  localparam logic [7:0] TtoCtl = 8'h24;
  localparam logic [7:0] TtoDat = 8'h25;
  localparam logic [7:0] OthCtl = 8'h28;

  nova_tty #(
    .CLK_DIV (16'd8)
  ) dut (
    .pclk     (pclk),
    .prst_n   (prst_n),
    .bs_stb   (bs_stb),
    .bs_we    (bs_we),
    .bs_adr   (bs_adr),
    .bs_din   (bs_din),
    .bs_dout  (bs_dout),
    .uart_rx  (uart_rx),
    .uart_tx  (uart_tx),
    .tty_intr (tty_intr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic bus_wr(input logic [7:0] adr, input logic [15:0] din);
    @(posedge pclk);
    #1;
    bs_stb = 1'b1;
    bs_we  = 1'b1;
    bs_adr = adr;
    bs_din = din;
    @(posedge pclk);
    #1;
    bs_stb = 1'b0;
    bs_we  = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] adr, output logic [15:0] dat);
    @(posedge pclk);
    #1;
    bs_stb = 1'b1;
    bs_we  = 1'b0;
    bs_adr = adr;
    @(posedge pclk);
    #1;
    bs_stb = 1'b0;
    dat    = bs_dout;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = fr[i];
      repeat (8) @(posedge pclk);
      #1;
    end
    uart_rx = 1'b1;
    repeat (8) @(posedge pclk);
    #1;
  endtask

  initial begin
    logic [15:0] d;
    logic [9:0]  frame;
    logic        stayed_high;
    int          c0;

    total   = 0;
    bad     = 0;
    cyc     = 0;
    prst_n  = 1'b0;
    bs_stb  = 1'b0;
    bs_we   = 1'b0;
    bs_adr  = 8'h00;
    bs_din  = 16'h0000;
    uart_rx = 1'b1;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    prst_n = 1'b1;

    // 1. reset state
    bus_rd(TtoCtl, d);
    chk("rst_tto_status", d, 16'h0000);
    chk("rst_uart_tx", {15'b0, uart_tx}, 16'h0001);
    chk("rst_intr", {15'b0, tty_intr}, 16'h0000);

    // 2. transmit 'A'
    bus_wr(TtoDat, 16'h0041);
    bus_wr(TtoCtl, 16'h0001);
    c0 = cyc;
    chk("tx_idle_on_start_edge", {15'b0, uart_tx}, 16'h0001);
    frame = 10'b1_0100_0001_0;
    for (int k = 0; k < 10; k++) begin
      wait_until(c0 + 5 + 8 * k);
      chk($sformatf("tx_bit%0d", k), {15'b0, uart_tx}, {15'b0, frame[k]});
      if (k == 0) begin
        bus_rd(TtoCtl, d);
        chk("tx_busy_status", d, 16'h8000);
      end
    end
    wait_until(c0 + 79);
    chk("tx_intr_before_end", {15'b0, tty_intr}, 16'h0000);
    wait_until(c0 + 80);
    chk("tx_intr_at_end", {15'b0, tty_intr}, 16'h0001);
    bus_rd(TtoCtl, d);
    chk("tx_done_status", d, 16'h4000);
    bus_rd(TtoDat, d);
    chk("tto_buf_read", d, 16'h0041);
    bus_wr(TtoCtl, 16'h0002);
    chk("tto_clear_intr", {15'b0, tty_intr}, 16'h0000);

    // 3. receive 0x5A
    send_rx(8'h5A, 1'b1);
    bus_rd(TtiCtl, d);
    chk("rx_done_status", d, 16'h4000);
    chk("rx_intr", {15'b0, tty_intr}, 16'h0001);
    bus_rd(TtiDat, d);
    chk("rx_data", d, 16'h005A);
    bus_wr(TtiCtl, 16'h0002);
    bus_rd(TtiCtl, d);
    chk("rx_clear_status", d, 16'h0000);
    chk("rx_clear_intr", {15'b0, tty_intr}, 16'h0000);

    // 4. framing error, then a short glitch
    send_rx(8'hC3, 1'b0);
    bus_rd(TtiCtl, d);
    chk("rx_frame_err_status", d, 16'h0000);
    bus_rd(TtiDat, d);
    chk("rx_frame_err_buf", d, 16'h005A);
    @(posedge pclk);
    #1;
    uart_rx = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    uart_rx = 1'b1;
    repeat (100) @(posedge pclk);
    #1;
    bus_rd(TtiCtl, d);
    chk("rx_glitch_status", d, 16'h0000);
    bus_rd(TtiDat, d);
    chk("rx_glitch_buf", d, 16'h005A);

    // 5. abort with Clear at cycle 30, then Start while busy
    bus_wr(TtoDat, 16'h00F0);
    bus_wr(TtoCtl, 16'h0001);
    c0 = cyc;
    wait_until(c0 + 29);
    chk("abort_pre_low", {15'b0, uart_tx}, 16'h0000);
    bus_wr(TtoCtl, 16'h0002);
    @(posedge pclk);
    #1;
    chk("abort_tx_high", {15'b0, uart_tx}, 16'h0001);
    stayed_high = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge pclk);
      #1;
      if (uart_tx !== 1'b1) stayed_high = 1'b0;
    end
    chk("abort_tx_stays_high", {15'b0, stayed_high}, 16'h0001);
    bus_rd(TtoCtl, d);
    chk("abort_status", d, 16'h0000);
    chk("abort_intr", {15'b0, tty_intr}, 16'h0000);

    bus_wr(TtoCtl, 16'h0001);
    c0 = cyc;
    wait_until(c0 + 19);
    bus_wr(TtoCtl, 16'h0001);
    wait_until(c0 + 79);
    chk("restart_intr_before_end", {15'b0, tty_intr}, 16'h0000);
    wait_until(c0 + 80);
    chk("restart_intr_at_end", {15'b0, tty_intr}, 16'h0001);
    bus_rd(TtoCtl, d);
    chk("restart_done_status", d, 16'h4000);

    // 6. foreign device, then reset mid-frame
    bus_rd(OthCtl, d);
    chk("other_dev_read", d, 16'h0000);
    bus_wr(TtoCtl, 16'h0001);
    c0 = cyc;
    wait_until(c0 + 5);
    chk("rst_pre_tx_low", {15'b0, uart_tx}, 16'h0000);
    bus_rd(TtoCtl, d);
    chk("rst_pre_status", d, 16'h8000);
    #2;
    prst_n = 1'b0;
    #1;
    chk("rst_async_tx", {15'b0, uart_tx}, 16'h0001);
    chk("rst_async_dout", bs_dout, 16'h0000);
    chk("rst_async_intr", {15'b0, tty_intr}, 16'h0000);
    @(negedge pclk);
    prst_n = 1'b1;
    bus_rd(TtoCtl, d);
    chk("rst_tto_flags", d, 16'h0000);
    bus_rd(TtoDat, d);
    chk("rst_tto_buf", d, 16'h0000);
    bus_rd(TtiDat, d);
    chk("rst_tti_buf", d, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
